ascon_stream_driver: RTL and testbench

//  Host-side transmitter for the ASCON-128 encryption core: turns a byte stream
//  (AD bytes, then plaintext) into padded 64-bit blocks and sequences the core's

---
 rtl/ascon_stream_driver.sv | 201 ++++++++++++++++++++
 tb/tb_ascon_stream_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_stream_driver.sv
// Host-side byte-stream front end for an ASCON-128 core: packs AD/PT bytes into
// padded 64-bit blocks, paces the core handshake, and returns ciphertext and tag.
module ascon_stream_driver #(
  parameter int INIT_WAIT = 16,
  parameter int BLK_WAIT  = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [7:0]   msg_byte_i,
  input  logic         msg_is_ad_i,
  input  logic         msg_last_i,
  output logic [127:0] key_o,
  output logic [127:0] nonce_o,
  output logic         start_o,
  output logic         data_valid_o,
  output logic [63:0]  data_xor_up_o,
  input  logic         cipher_valid_i,
  input  logic [63:0]  cipher_i,
  input  logic         end_i,
  input  logic [127:0] tag_i,
  output logic         ct_valid_o,
  output logic [63:0]  ct_data_o,
  output logic [3:0]   ct_bytes_o,
  output logic         tag_valid_o,
  output logic [127:0] tag_o,
  output logic         busy_o,
  output logic         error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_SEND, S_WAIT_AD, S_WAIT_CT, S_WAIT_END
  } state_t;

  // Descriptor of the block currently held on data_xor_up_o.
  typedef struct packed {
    logic       is_ad;
    logic       last;    // final PT block: after its ciphertext, wait for end_i
    logic [3:0] nbytes;  // PT payload bytes (0 for pad block / AD)
  } blk_t;

  localparam int TW = $clog2(INIT_WAIT + BLK_WAIT + TIMEOUT);

  state_t         state, state_d;
  logic [TW-1:0]  tmr;
  logic [63:0]    acc_q;
  logic [2:0]     bcnt;
  blk_t           blk;
  logic           pt_started, pad_pending, pad_is_ad;

  logic           take, ad_err, closes, tmo, err_set;
  logic [3:0]     nb;
  logic [63:0]    acc_nx, pad_blk;

  function automatic logic [63:0] byte_mask(input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++)
      m[63-8*k -: 8] = (k < int'(n)) ? 8'hff : 8'h00;
    return m;
  endfunction

  assign msg_ready_o  = (state == S_FILL) && !pad_pending;
  assign data_valid_o = (state == S_SEND);
  assign busy_o       = (state != S_IDLE);

  assign take    = msg_valid_i && msg_ready_o;
  assign ad_err  = take && msg_is_ad_i && pt_started;
  assign closes  = take && !ad_err && ((bcnt == 3'd7) || msg_last_i);
  assign nb      = {1'b0, bcnt} + 4'd1;
  assign acc_nx  = acc_q | ({56'd0, msg_byte_i} << (6'd56 - {bcnt, 3'b000}));
  // Pad byte lands right after the last payload byte; full blocks get no pad here.
  assign pad_blk = (nb == 4'd8) ? acc_nx
                 : acc_nx | (64'h80 << (6'd48 - {bcnt, 3'b000}));
  assign tmo     = (tmr == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    err_set = 1'b0;
    case (state)
      S_IDLE:    if (start_i) state_d = S_INIT;
      S_INIT:    if (tmr == TW'(INIT_WAIT - 1)) state_d = S_FILL;
      S_FILL: begin
        if (ad_err) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (pad_pending || closes) begin
          state_d = S_SEND;
        end
      end
      S_SEND:    state_d = blk.is_ad ? S_WAIT_AD : S_WAIT_CT;
      S_WAIT_AD: begin
        if (cipher_valid_i) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (tmr == TW'(BLK_WAIT - 1)) begin
          state_d = S_FILL;
        end
      end
      S_WAIT_CT: begin
        if (cipher_valid_i) state_d = blk.last ? S_WAIT_END : S_FILL;
        else if (tmo) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_END: begin
        if (end_i) state_d = S_IDLE;
        else if (tmo) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) state <= S_IDLE;
    else           state <= state_d;
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      tmr           <= '0;
      acc_q         <= '0;
      bcnt          <= '0;
      blk           <= '0;
      pt_started    <= 1'b0;
      pad_pending   <= 1'b0;
      pad_is_ad     <= 1'b0;
      key_o         <= '0;
      nonce_o       <= '0;
      start_o       <= 1'b0;
      data_xor_up_o <= '0;
      ct_valid_o    <= 1'b0;
      ct_data_o     <= '0;
      ct_bytes_o    <= '0;
      tag_valid_o   <= 1'b0;
      tag_o         <= '0;
      error_o       <= 1'b0;
    end else begin
      start_o     <= 1'b0;
      ct_valid_o  <= 1'b0;
      tag_valid_o <= 1'b0;
      tmr         <= (state_d != state) ? '0 : tmr + 1'b1;
      if (err_set) error_o <= 1'b1;
      case (state)
        S_IDLE: if (start_i) begin
          key_o       <= key_i;
          nonce_o     <= nonce_i;
          error_o     <= 1'b0;
          start_o     <= 1'b1;
          acc_q       <= '0;
          bcnt        <= '0;
          pt_started  <= 1'b0;
          pad_pending <= 1'b0;
        end
        S_FILL: begin
          if (pad_pending) begin
            data_xor_up_o <= 64'h8000_0000_0000_0000;
            blk           <= '{is_ad: pad_is_ad, last: !pad_is_ad, nbytes: 4'd0};
            pad_pending   <= 1'b0;
          end else if (take && !ad_err) begin
            if (!msg_is_ad_i) pt_started <= 1'b1;
            if (closes) begin
              data_xor_up_o <= pad_blk;
              blk           <= '{is_ad:  msg_is_ad_i,
                                 last:   !msg_is_ad_i && msg_last_i && (nb != 4'd8),
                                 nbytes: msg_is_ad_i ? 4'd0 : nb};
              // A phase ending on a full block still owes a pure-padding block.
              pad_pending   <= msg_last_i && (nb == 4'd8);
              pad_is_ad     <= msg_is_ad_i;
              acc_q         <= '0;
              bcnt          <= '0;
            end else begin
              acc_q <= acc_nx;
              bcnt  <= bcnt + 3'd1;
            end
          end
        end
        S_WAIT_CT: if (cipher_valid_i) begin
          ct_valid_o <= 1'b1;
          ct_data_o  <= cipher_i & byte_mask(blk.nbytes);
          ct_bytes_o <= blk.nbytes;
        end
        S_WAIT_END: if (end_i) begin
          tag_o       <= tag_i;
          tag_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_stream_driver.sv
// Randomized bench for ascon_stream_driver: a host driver, a toy core responder and
// a block-level reference model of padding, ciphertext masking and the tag return.
module tb_ascon_stream_driver;
  logic         clock_i = 1'b0;
  logic         resetb_i, start_i, msg_valid_i, msg_ready_o, msg_is_ad_i, msg_last_i;
  logic [127:0] key_i, nonce_i, key_o, nonce_o, tag_i, tag_o;
  logic [7:0]   msg_byte_i;
  logic         start_o, data_valid_o, cipher_valid_i, end_i, ct_valid_o, tag_valid_o;
  logic         busy_o, error_o;
  logic [63:0]  data_xor_up_o, cipher_i, ct_data_o;
  logic [3:0]   ct_bytes_o;

  always #5 clock_i = ~clock_i;

  ascon_stream_driver dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .key_i(key_i),
    .nonce_i(nonce_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .msg_byte_i(msg_byte_i), .msg_is_ad_i(msg_is_ad_i), .msg_last_i(msg_last_i),
    .key_o(key_o), .nonce_o(nonce_o), .start_o(start_o), .data_valid_o(data_valid_o),
    .data_xor_up_o(data_xor_up_o), .cipher_valid_i(cipher_valid_i), .cipher_i(cipher_i),
    .end_i(end_i), .tag_i(tag_i), .ct_valid_o(ct_valid_o), .ct_data_o(ct_data_o),
    .ct_bytes_o(ct_bytes_o), .tag_valid_o(tag_valid_o), .tag_o(tag_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]   ad_q[$], pt_q[$];
  logic [63:0]  exp_blk[$], got_blk[$], cipher_sent[$], got_ct[$];
  int           exp_n[$];
  logic [3:0]   got_ctb[$];
  logic [127:0] got_tag[$], tag_sent, key_r;
  int           nad, blk_seen, proto_bad;
  bit           core_on = 1'b1, have_dxu;
  logic [63:0]  last_dxu;

  // Each phase of L bytes yields L/8 full chunks plus one final chunk of L%8
  // bytes (possibly empty) that carries the 0x80 pad byte.
  function automatic void add_phase(input bit is_ad);
    int L, n;
    logic [63:0] b;
    L = is_ad ? ad_q.size() : pt_q.size();
    if (L == 0) return;
    for (int j = 0; j <= L / 8; j++) begin
      n = (L - 8 * j > 8) ? 8 : L - 8 * j;
      b = '0;
      for (int k = 0; k < n; k++) b[63-8*k -: 8] = is_ad ? ad_q[8*j+k] : pt_q[8*j+k];
      if (n < 8) b[63-8*n -: 8] = 8'h80;
      exp_blk.push_back(b);
      if (is_ad) nad++; else exp_n.push_back(n);
    end
  endfunction

  function automatic logic [63:0] keep_bytes(input logic [63:0] v, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[63-8*k -: 8] = v[63-8*k -: 8];
    return r;
  endfunction

  // Toy core: answers every PT block with random ciphertext, then end_i + tag.
  initial begin
    cipher_valid_i = 1'b0; end_i = 1'b0; cipher_i = '0; tag_i = '0;
    forever begin
      @(negedge clock_i);
      if (data_valid_o) begin
        blk_seen++;
        got_blk.push_back(data_xor_up_o);
        if (core_on && blk_seen > nad) begin
          repeat ($urandom_range(1, 4)) @(negedge clock_i);
          cipher_i = {$urandom, $urandom};
          cipher_sent.push_back(cipher_i);
          cipher_valid_i = 1'b1;
          @(negedge clock_i);
          cipher_valid_i = 1'b0;
          if (blk_seen == exp_blk.size()) begin
            repeat ($urandom_range(1, 4)) @(negedge clock_i);
            tag_sent = {$urandom, $urandom, $urandom, $urandom};
            tag_i = tag_sent; end_i = 1'b1;
            @(negedge clock_i);
            end_i = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clock_i) begin
    if (ct_valid_o) begin got_ct.push_back(ct_data_o); got_ctb.push_back(ct_bytes_o); end
    if (tag_valid_o) got_tag.push_back(tag_o);
    if (data_valid_o) begin
      if (msg_ready_o) proto_bad++;
      last_dxu = data_xor_up_o;
      have_dxu = 1'b1;
    end else if (have_dxu && data_xor_up_o !== last_dxu) begin
      proto_bad++;
    end
  end

  task automatic do_start();
    @(negedge clock_i);
    key_i = {$urandom, $urandom, $urandom, $urandom};
    nonce_i = {$urandom, $urandom, $urandom, $urandom};
    key_r = key_i;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    check("start_o", start_o, 1);
    check("key_o", key_o, key_r);
    check("err_clr", error_o, 0);
    check("busy_run", busy_o, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_ad, input bit last);
    repeat ($urandom_range(0, 2)) @(negedge clock_i);
    msg_valid_i = 1'b1; msg_byte_i = b; msg_is_ad_i = is_ad; msg_last_i = last;
    for (int t = 0; t < 400; t++) begin
      if (msg_ready_o) begin
        @(negedge clock_i);
        msg_valid_i = 1'b0;
        return;
      end
      @(negedge clock_i);
    end
    check("accept_timeout", 0, 1);
    msg_valid_i = 1'b0;
  endtask

  task automatic run_msg(input string name);
    exp_blk.delete(); exp_n.delete(); nad = 0;
    add_phase(1'b1); add_phase(1'b0);
    got_blk.delete(); got_ct.delete(); got_ctb.delete(); got_tag.delete();
    cipher_sent.delete();
    blk_seen = 0; proto_bad = 0; have_dxu = 1'b0; core_on = 1'b1;
    do_start();
    foreach (ad_q[i]) send_byte(ad_q[i], 1'b1, i == ad_q.size() - 1);
    foreach (pt_q[i]) send_byte(pt_q[i], 1'b0, i == pt_q.size() - 1);
    for (int t = 0; t < 1000 && got_tag.size() == 0; t++) @(negedge clock_i);
    repeat (3) @(negedge clock_i);
    check({name, "_nblk"}, got_blk.size(), exp_blk.size());
    foreach (got_blk[i])
      if (i < exp_blk.size()) check($sformatf("%s_blk%0d", name, i), got_blk[i], exp_blk[i]);
    check({name, "_nct"}, got_ct.size(), exp_n.size());
    foreach (got_ct[i])
      if (i < exp_n.size() && i < cipher_sent.size()) begin
        check($sformatf("%s_ct%0d", name, i), got_ct[i], keep_bytes(cipher_sent[i], exp_n[i]));
        check($sformatf("%s_ctb%0d", name, i), got_ctb[i], exp_n[i]);
      end
    check({name, "_ntag"}, got_tag.size(), 1);
    if (got_tag.size() > 0) check({name, "_tag"}, got_tag[0], tag_sent);
    check({name, "_proto"}, proto_bad, 0);
    check({name, "_idle"}, {busy_o, error_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetb_i = 1'b0; start_i = 1'b0; msg_valid_i = 1'b0; msg_byte_i = '0;
    msg_is_ad_i = 1'b0; msg_last_i = 1'b0; key_i = '0; nonce_i = '0;
    repeat (3) @(negedge clock_i);
    check("rst_ctl", {busy_o, msg_ready_o, start_o, data_valid_o, ct_valid_o,
                      tag_valid_o, error_o}, 0);
    check("rst_dat", {data_xor_up_o, ct_data_o, ct_bytes_o}, 0);
    resetb_i = 1'b1;

    // AD 01 02 03, full 8-byte PT block followed by a pad block
    ad_q = '{8'h01, 8'h02, 8'h03};
    pt_q.delete();
    for (int i = 0; i < 8; i++) pt_q.push_back(8'($urandom));
    run_msg("t1");
    if (got_blk.size() == 3) begin
      check("t1_ad_const", got_blk[0], 64'h0102_0380_0000_0000);
      check("t1_pad_const", got_blk[2], 64'h8000_0000_0000_0000);
    end
    if (got_ctb.size() == 2) check("t1_ctb", {got_ctb[0], got_ctb[1]}, {4'd8, 4'd0});

    // No AD, 5-byte PT
    ad_q.delete();
    pt_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_msg("t2");
    if (got_blk.size() == 1) check("t2_blk_const", got_blk[0], 64'hAABB_CCDD_EE80_0000);
    if (got_ct.size() == 1) check("t2_low_zero", got_ct[0][23:0], 0);

    // Random messages, lengths chosen to straddle block boundaries
    for (int m = 0; m < 6; m++) begin
      int la, lp;
      la = (m == 0) ? 8 : $urandom_range(0, 17);
      lp = (m == 0) ? 16 : $urandom_range(1, 17);
      ad_q.delete(); pt_q.delete();
      for (int i = 0; i < la; i++) ad_q.push_back(8'($urandom));
      for (int i = 0; i < lp; i++) pt_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", m));
    end

    // AD byte after PT has started
    do_start();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    check("aderr_err", error_o, 1);
    check("aderr_busy", busy_o, 0);
    ad_q = '{8'h33}; pt_q = '{8'h44, 8'h55};
    run_msg("after_err");

    // Core never answers: timeout in WAIT_CT
    exp_blk.delete(); nad = 0; got_ct.delete(); blk_seen = 0; core_on = 1'b0;
    do_start();
    msg_valid_i = 1'b1; msg_byte_i = 8'h5A; msg_is_ad_i = 1'b0; msg_last_i = 1'b1;
    begin
      int t;
      for (t = 0; t < 200 && !data_valid_o; t++) @(negedge clock_i);
      msg_valid_i = 1'b0;
      check("tmo_sent", (t < 200), 1);
    end
    repeat (60) @(negedge clock_i);
    check("tmo_early", {error_o, busy_o}, 2'b01);
    repeat (10) @(negedge clock_i);
    check("tmo_late", {error_o, busy_o}, 2'b10);
    check("tmo_noct", got_ct.size(), 0);
    core_on = 1'b1;

    // Reset in the middle of FILL
    do_start();
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b1, 1'b0);
    @(negedge clock_i);
    resetb_i = 1'b0;
    @(negedge clock_i);
    check("rstmid_ctl", {busy_o, msg_ready_o, start_o, data_valid_o, ct_valid_o,
                         tag_valid_o, error_o}, 0);
    check("rstmid_dat", {data_xor_up_o, ct_bytes_o}, 0);
    check("rstmid_key", key_o, 0);
    resetb_i = 1'b1;
    ad_q = '{8'hA1, 8'hA2}; pt_q = '{8'hB1, 8'hB2, 8'hB3};
    run_msg("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
